// File: rtl/apb_master_pkg.sv
// Shared types for the APB master: FSM state encoding and the response record.
package apb_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_RESP
    } apb_mst_state_e;

    localparam int RSP_DATA_W = 16;

    typedef struct packed {
        logic [RSP_DATA_W-1:0] rdata;
        logic                  err;
        logic                  timeout;
    } apb_rsp_t;

endpackage

// File: rtl/apb_master_ctrl_wait_timer.sv
// Wait-state counter for the ACCESS phase; expired flags the last allowed ACCESS cycle.
module apb_wait_timer #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_inputs;
            assign unused_inputs = &{1'b0, clk, rst_n, clr_i, en_i};
            assign expired_o     = 1'b0;
        end else begin : g_on
            localparam int              CNT_W = $clog2(TIMEOUT + 1);
            localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

            logic [CNT_W-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clr_i) begin
                    cnt_d = '0;
                end else if (en_i && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            // Count holds the number of finished wait cycles, so the TIMEOUT-th
            // ACCESS cycle is the one where it sits at TIMEOUT-1.
            assign expired_o = (cnt_q >= (LIMIT - 1'b1));
        end
    endgenerate

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master: one outstanding command at a time, turned into SETUP/ACCESS and a response.
module apb_master_ctrl
    import apb_master_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int NUM_SEL = 16,
    parameter int TIMEOUT = 256,
    localparam int SEL_W  = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    input  logic               cmd_write,
    input  logic [SEL_W-1:0]   cmd_sel,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    output logic               rsp_timeout,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [DATA_W-1:0]  PWDATA,
    output logic               PWRITE,
    output logic [NUM_SEL-1:0] PSEL,
    output logic               PENABLE,
    input  logic [DATA_W-1:0]  PRDATA,
    input  logic               PREADY,
    input  logic               PSLVERR
);

    localparam logic [NUM_SEL-1:0] PSEL_ONE = NUM_SEL'(1);

    apb_mst_state_e    state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              write_q, write_d;
    logic              err_q, err_d;
    logic              tmo_q, tmo_d;
    logic              sel_ok;
    logic              tmr_clr, tmr_en, tmr_expired;

    assign sel_ok = (32'(cmd_sel) < $unsigned(NUM_SEL));

    apb_wait_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .clr_i    (tmr_clr),
        .en_i     (tmr_en),
        .expired_o(tmr_expired)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        write_d = write_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tmo_d   = tmo_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    if (sel_ok) begin
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        write_d = cmd_write;
                        sel_d   = cmd_sel;
                        state_d = ST_SETUP;
                    end else begin
                        // Out-of-range select is answered locally without touching the bus.
                        rdata_d = '0;
                        err_d   = 1'b1;
                        tmo_d   = 1'b0;
                        state_d = ST_RESP;
                    end
                end
            end
            ST_SETUP: begin
                tmr_clr = 1'b1;
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (tmr_expired) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    tmo_d   = 1'b1;
                    state_d = ST_RESP;
                end else if (PREADY) begin
                    rdata_d = (!write_q && !PSLVERR) ? PRDATA : '0;
                    err_d   = PSLVERR;
                    tmo_d   = 1'b0;
                    state_d = ST_RESP;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        cmd_ready_d = (state_d == ST_IDLE);
    end

    // cmd_ready is its own flop so it stays low while PRESETn is asserted.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            sel_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            sel_q       <= sel_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign cmd_ready   = cmd_ready_q;
    assign PADDR       = addr_q;
    assign PWDATA      = wdata_q;
    assign PWRITE      = write_q;
    assign PSEL        = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? (PSEL_ONE << sel_q) : '0;
    assign PENABLE     = (state_q == ST_ACCESS);
    assign rsp_valid   = (state_q == ST_RESP);
    assign rsp_rdata   = rdata_q;
    assign rsp_err     = err_q;
    assign rsp_timeout = tmo_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl with NUM_SEL=5, TIMEOUT=8: vector table, slave responder, response scoreboard.
module tb_apb_master_ctrl;
    import apb_master_pkg::*;

    localparam int NSEL = 5;
    localparam int TMO  = 8;

    logic        PCLK;
    logic        PRESETn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_sel;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [15:0] rsp_rdata;
    logic [15:0] PADDR, PWDATA, PRDATA;
    logic        PWRITE, PENABLE, PREADY, PSLVERR;
    logic [4:0]  PSEL;

    apb_master_ctrl #(
        .ADDR_W (16),
        .DATA_W (16),
        .NUM_SEL(NSEL),
        .TIMEOUT(TMO)
    ) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_wdata  (cmd_wdata),
        .cmd_write  (cmd_write),
        .cmd_sel    (cmd_sel),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR      (PADDR),
        .PWDATA     (PWDATA),
        .PWRITE     (PWRITE),
        .PSEL       (PSEL),
        .PENABLE    (PENABLE),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    typedef struct {
        logic        write;
        logic [2:0]  sel;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          waits;
        logic [15:0] prdata;
        logic        slverr;
        logic [15:0] exp_rdata;
        logic        exp_err;
        logic        exp_tmo;
        int          exp_acc;
    } vec_t;

    vec_t     vecs[10];
    apb_rsp_t sb_q[$];
    apb_rsp_t mon_e;
    int       total;
    int       bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic do_cmd(input vec_t v);
        int         guard;
        int         lat;
        int         setup;
        int         acc;
        logic       good;
        logic [4:0] exp_psel;
        apb_rsp_t   e;
        good     = (int'(v.sel) < NSEL);
        exp_psel = good ? (5'd1 << v.sel) : 5'd0;
        cmd_valid = 1'b1;
        cmd_write = v.write;
        cmd_sel   = v.sel;
        cmd_addr  = v.addr;
        cmd_wdata = v.wdata;
        guard = 0;
        while (!cmd_ready && guard < 10) begin
            tick();
            guard++;
        end
        check("cmd_ready_before_accept", 32'(cmd_ready), 32'd1);
        e.rdata   = v.exp_rdata;
        e.err     = v.exp_err;
        e.timeout = v.exp_tmo;
        sb_q.push_back(e);
        tick();
        cmd_valid = 1'b0;
        lat   = 0;
        setup = 0;
        acc   = 0;
        while (!rsp_valid && lat < 40) begin
            PREADY  = 1'b0;
            PSLVERR = 1'b0;
            PRDATA  = 16'hDEAD;
            if (PSEL != 5'd0 && !PENABLE) begin
                setup++;
                check("psel_setup", 32'(PSEL), 32'(exp_psel));
            end
            if (PENABLE) begin
                acc++;
                check("psel_access", 32'(PSEL), 32'(exp_psel));
                check("paddr", 32'(PADDR), 32'(v.addr));
                check("pwrite", 32'(PWRITE), 32'(v.write));
                if (v.write) check("pwdata", 32'(PWDATA), 32'(v.wdata));
                if (acc > v.waits) begin
                    PREADY  = 1'b1;
                    PRDATA  = v.prdata;
                    PSLVERR = v.slverr;
                end
            end
            tick();
            lat++;
        end
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        PRDATA  = 16'h0000;
        check("rsp_latency", 32'(lat), good ? 32'(v.exp_acc + 1) : 32'd0);
        check("setup_cycles", 32'(setup), good ? 32'd1 : 32'd0);
        check("access_cycles", 32'(acc), 32'(v.exp_acc));
        check("psel_in_resp", 32'(PSEL), 32'd0);
        check("penable_in_resp", 32'(PENABLE), 32'd0);
        check("cmd_ready_in_resp", 32'(cmd_ready), 32'd0);
        tick();
        check("back_to_idle", 32'({rsp_valid, cmd_ready}), 32'b01);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        //          wr    sel   addr      wdata     wt   prdata    err   exp_rd    e_err e_tmo acc
        vecs[0] = '{1'b1, 3'd3, 16'h0010, 16'hA5A5, 0,   16'h7777, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 3'd0, 16'h0004, 16'h0000, 6,   16'h1234, 1'b0, 16'h1234, 1'b0, 1'b0, 7};
        vecs[2] = '{1'b0, 3'd1, 16'h0008, 16'h0000, 0,   16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 3'd2, 16'h0020, 16'h0000, 100, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 8};
        vecs[4] = '{1'b0, 3'd4, 16'h0030, 16'h0000, 2,   16'hBEEF, 1'b0, 16'hBEEF, 1'b0, 1'b0, 3};
        vecs[5] = '{1'b0, 3'd1, 16'h0034, 16'h0000, 7,   16'h4444, 1'b0, 16'h0000, 1'b1, 1'b1, 8};
        vecs[6] = '{1'b1, 3'd0, 16'h0100, 16'h3C3C, 1,   16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, 2};
        vecs[7] = '{1'b0, 3'd5, 16'h0200, 16'h0000, 0,   16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
        vecs[8] = '{1'b1, 3'd7, 16'h0300, 16'h1111, 0,   16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
        vecs[9] = '{1'b0, 3'd2, 16'h0044, 16'h0000, 0,   16'h5A5A, 1'b0, 16'h5A5A, 1'b0, 1'b0, 1};

        PRESETn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_sel   = 3'd0;
        cmd_addr  = 16'h0000;
        cmd_wdata = 16'h0000;
        rsp_ready = 1'b1;
        PRDATA    = 16'h0000;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;

        fork
            forever begin
                @(negedge PCLK);
                if (PRESETn && rsp_valid && rsp_ready) begin
                    if (sb_q.size() == 0) begin
                        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
                    end else begin
                        mon_e = sb_q.pop_front();
                        check("rsp_rdata", 32'(rsp_rdata), 32'(mon_e.rdata));
                        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
                        check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.timeout));
                    end
                end
            end
        join_none

        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_psel", 32'(PSEL), 32'd0);
        check("rst_penable", 32'(PENABLE), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_paddr", 32'(PADDR), 32'd0);
        check("rst_rsp_err", 32'(rsp_err), 32'd0);
        PRESETn = 1'b1;
        #1;
        check("cmd_ready_before_first_edge", 32'(cmd_ready), 32'd0);
        tick();
        check("cmd_ready_after_release", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < 10; i++) begin
            do_cmd(vecs[i]);
        end

        // Bad select held in RESP by backpressure.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_sel   = 3'd5;
        cmd_addr  = 16'h0ABC;
        sb_q.push_back('{rdata: 16'h0000, err: 1'b1, timeout: 1'b0});
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_payload", 32'({rsp_rdata, rsp_err, rsp_timeout}), 32'({16'h0000, 1'b1, 1'b0}));
            check("stall_cmd_ready", 32'(cmd_ready), 32'd0);
            check("stall_psel", 32'(PSEL), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("stall_release_idle", 32'({rsp_valid, cmd_ready}), 32'b01);

        // Reset while a read is waiting in ACCESS.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_sel   = 3'd1;
        cmd_addr  = 16'h0040;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("pre_reset_penable", 32'(PENABLE), 32'd1);
        tick();
        PRESETn = 1'b0;
        #1;
        check("async_rst_psel", 32'(PSEL), 32'd0);
        check("async_rst_penable", 32'(PENABLE), 32'd0);
        check("async_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("async_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        PRESETn = 1'b1;
        tick();
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            check("no_stale_rsp", 32'(rsp_valid), 32'd0);
            tick();
        end

        do_cmd(vecs[4]);
        repeat (2) tick();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
